conv_frame_scheduler: RTL
=========================

// Module: conv_frame_scheduler
// PURPOSE
//  Sequences one IX x IY frame from a synchronous pixel memory into the KXxKY line buffer, one pixel per push.
//  Tracks the raster position of every pushed pixel, flags each push that completes a full window, and throttles reads on downstream conv ready.
//  Provides start/abort/done control to the top-level frame controller and a one-cycle line-buffer resync reset.
// PARAMETERS
//  I_F_BW   8              pixel width (bits)
//  IX       28             frame width (pixels)
//  IY       28             frame height (pixels)
//  KX       5              kernel width
//  KY       5              kernel height
//  RD_LAT   1              pixel-memory read latency (cycles, >=1)
//  AW       $clog2(IX*IY)  memory address width (localparam)
// PORTS
//  clk           in   1                  system clock
//  reset_n       in   1                  synchronous active-low reset
//  i_start       in   1                  begin frame (sampled only in IDLE)
//  i_abort       in   1                  abandon frame, return to IDLE
//  i_conv_ready  in   1                  downstream conv accepts windows
//  o_rd_en       out  1                  pixel-memory read strobe
//  o_rd_addr     out  AW                 raster address y*IX+x
//  i_rd_data     in   I_F_BW             memory data, valid RD_LAT cycles after o_rd_en
//  o_lb_valid    out  1                  push strobe to line buffer
//  o_lb_pixel    out  I_F_BW             pixel to line buffer
//  o_lb_reset_n  out  1                  line-buffer resync reset, active-low
//  o_win_fire    out  1                  this push completes a valid window
//  o_win_x       out  $clog2(IX-KX+1)    window left column on fire
//  o_win_y       out  $clog2(IY-KY+1)    window top row on fire
//  o_busy        out  1                  frame in progress (FETCH/DRAIN)
//  o_done        out  1                  one-cycle pulse, frame complete
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): all outputs 0 except o_lb_reset_n=0; state IDLE, counters 0, delay pipe cleared.
//  FSM: IDLE -> FETCH on i_start; FETCH -> DRAIN after read of addr IX*IY-1; DRAIN -> DONE when pipe empty; DONE -> IDLE (1 cycle, o_done=1).
//  Any state -> IDLE on i_abort (abort beats start in same cycle); o_lb_reset_n=0 for exactly the next cycle.
//  Read issue: o_rd_en=1 in FETCH iff i_conv_ready=1; rd x/y/addr advance only on issued read; x wraps IX-1->0 with y+1.
//  Stall: i_conv_ready=0 holds address; up to RD_LAT in-flight pixels still push (conv side provides RD_LAT skid).
//  Push path: RD_LAT-deep shift of {valid,x,y}; o_lb_valid/o_lb_pixel = i_rd_data with tag valid, registered 0 extra cycles.
//  Latency: o_rd_en at cycle t -> o_lb_valid at t+RD_LAT, o_win_fire same cycle as that push.
//  o_win_fire = o_lb_valid && x>=KX-1 && y>=KY-1; o_win_x=x-(KX-1), o_win_y=y-(KY-1).
//  Per frame: exactly IX*IY pushes, (IX-KX+1)*(IY-KY+1) fires (576 at defaults), in raster order.
//  Abort: pipe valid bits cleared same edge; no o_lb_valid/o_win_fire after abort; o_done not asserted.
//  i_start ignored outside IDLE; i_start held high in IDLE after DONE starts next frame back-to-back.
//  o_busy=1 in FETCH and DRAIN only; o_lb_reset_n=1 otherwise (also pulses 0 on entering FETCH from IDLE).
//  All counters exact width; no wrap beyond IX*IY-1; reset mid-frame behaves as abort plus full clear.
// STRUCTURE
//  conv_pkg: state enum (IDLE,FETCH,DRAIN,DONE), frame/kernel defaults, window-count constant.
//  Sub-module raster_addr_gen: x/y/addr counter with enable, last flag, sync clear.
//  Top: FSM, RD_LAT tag pipe, window-fire compare.
// TESTING
//  Reset then start, ready=1 const -> 784 o_lb_valid, 576 o_win_fire, first fire at push 116 (x=4,y=4), o_done 1 cycle after last push.
//  Ready toggled 1/0 every 3 cycles -> identical pixel/fire sequence vs golden, no address skipped or repeated.
//  Abort at push 300 -> o_lb_reset_n low 1 cycle, zero pushes after, no o_done; restart yields full 576 fires.
//  Start+abort same cycle in IDLE -> stays IDLE, o_rd_en never asserted.
//  RD_LAT=3, ready drops on cycle of last read -> 3 in-flight pushes land, DRAIN 3 cycles, then DONE.
//  i_start held high -> second frame begins cycle after DONE; pulses in FETCH ignored.

Source files
------------

// File: rtl/conv_frame_scheduler_pkg.sv
// Shared types and defaults for the conv frame scheduler.
// Holds the FSM state enum, frame/kernel defaults and width helpers.
package conv_frame_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_I_F_BW = 8;
    localparam int DEF_IX     = 28;
    localparam int DEF_IY     = 28;
    localparam int DEF_KX     = 5;
    localparam int DEF_KY     = 5;
    localparam int DEF_RD_LAT = 1;

    function automatic int win_count(
        input int ix,
        input int iy,
        input int kx,
        input int ky
    );
        return (ix - kx + 1) * (iy - ky + 1);
    endfunction

    localparam int DEF_WIN_COUNT =
        win_count(DEF_IX, DEF_IY, DEF_KX, DEF_KY);

    // $clog2 that never yields a zero-width vector
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_frame_scheduler_raster_addr_gen.sv
// Raster x/y/address counter for one IX x IY frame.
// Ports: clk, reset_n, clr (sync clear), en (advance), x, y, addr, last.
module raster_addr_gen
    import conv_frame_scheduler_pkg::*;
#(
    parameter int   IX = DEF_IX,
    parameter int   IY = DEF_IY,
    localparam int  XW = cw(IX),
    localparam int  YW = cw(IY),
    localparam int  AW = cw(IX * IY)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(IX - 1);
    localparam logic [AW-1:0] A_MAX = AW'(IX * IY - 1);

    assign last = (addr == A_MAX);

    // The last address folds back to 0 so the next frame starts clean.
    always_ff @(posedge clk) begin
        if (!reset_n || clr || (en && last)) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (en) begin
            addr <= addr + 1'b1;
            if (x == X_MAX) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_frame_scheduler.sv
// Streams one frame from pixel memory into the KXxKY line buffer.
// Ports: clk/reset_n, i_start/i_abort/i_conv_ready control, o_rd_en/o_rd_addr/i_rd_data memory side,
// o_lb_valid/o_lb_pixel/o_lb_reset_n line buffer, o_win_fire/o_win_x/o_win_y window tag, o_busy/o_done status.
module conv_frame_scheduler
    import conv_frame_scheduler_pkg::*;
#(
    parameter int   I_F_BW = DEF_I_F_BW,
    parameter int   IX     = DEF_IX,
    parameter int   IY     = DEF_IY,
    parameter int   KX     = DEF_KX,
    parameter int   KY     = DEF_KY,
    parameter int   RD_LAT = DEF_RD_LAT,
    localparam int  AW     = cw(IX * IY),
    localparam int  WXW    = cw(IX - KX + 1),
    localparam int  WYW    = cw(IY - KY + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_conv_ready,
    output logic              o_rd_en,
    output logic [AW-1:0]     o_rd_addr,
    input  logic [I_F_BW-1:0] i_rd_data,
    output logic              o_lb_valid,
    output logic [I_F_BW-1:0] o_lb_pixel,
    output logic              o_lb_reset_n,
    output logic              o_win_fire,
    output logic [WXW-1:0]    o_win_x,
    output logic [WYW-1:0]    o_win_y,
    output logic              o_busy,
    output logic              o_done
);

    localparam int XW = cw(IX);
    localparam int YW = cw(IY);
    localparam logic [XW-1:0] KX_M1 = XW'(KX - 1);
    localparam logic [YW-1:0] KY_M1 = YW'(KY - 1);

    state_t state_q;
    state_t state_d;

    logic          rd_en;
    logic          start_go;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          rd_last;
    logic          lb_rst_n_q;

    // Tag pipe mirrors the memory latency so each returning word
    // arrives with its own raster position.
    logic [RD_LAT-1:0] pv;
    logic [XW-1:0]     px [RD_LAT];
    logic [YW-1:0]     py [RD_LAT];
    logic              pipe_busy;

    logic          tag_v;
    logic [XW-1:0] tag_x;
    logic [YW-1:0] tag_y;
    logic [XW-1:0] win_dx;
    logic [YW-1:0] win_dy;
    logic          fire;

    assign rd_en    = (state_q == S_FETCH) && i_conv_ready;
    assign start_go = (state_q == S_IDLE) && i_start && !i_abort;

    raster_addr_gen #(
        .IX (IX),
        .IY (IY)
    ) u_addr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (i_abort || start_go),
        .en      (rd_en),
        .x       (rd_x),
        .y       (rd_y),
        .addr    (o_rd_addr),
        .last    (rd_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The output stage is being consumed this cycle, so DRAIN may
    // leave once nothing is left in the earlier stages.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pipe_busy = pipe_busy | pv[i];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (i_start) state_d = S_FETCH;
            S_FETCH: if (rd_en && rd_last) state_d = S_DRAIN;
            S_DRAIN: if (!pipe_busy) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_abort) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pv <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
        end else if (i_abort) begin
            pv <= '0;
        end else begin
            pv[0] <= rd_en;
            px[0] <= rd_x;
            py[0] <= rd_y;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
        end
    end

    // Line buffer is resynced on the cycle after a start or abort.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lb_rst_n_q <= 1'b0;
        end else begin
            lb_rst_n_q <= !(i_abort || start_go);
        end
    end

    assign tag_v  = pv[RD_LAT-1];
    assign tag_x  = px[RD_LAT-1];
    assign tag_y  = py[RD_LAT-1];
    assign win_dx = tag_x - KX_M1;
    assign win_dy = tag_y - KY_M1;
    assign fire   = tag_v && (tag_x >= KX_M1) && (tag_y >= KY_M1);

    assign o_rd_en      = rd_en;
    assign o_lb_valid   = tag_v;
    assign o_lb_pixel   = tag_v ? i_rd_data : '0;
    assign o_lb_reset_n = lb_rst_n_q;
    assign o_win_fire   = fire;
    assign o_win_x      = fire ? WXW'(win_dx) : '0;
    assign o_win_y      = fire ? WYW'(win_dy) : '0;
    assign o_busy       = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign o_done       = (state_q == S_DONE);

endmodule
